apb_slave_mem_wait: RTL and testbench
=====================================

Name: apb_slave_mem_wait

Overview:
- Parametrised APB slave with an internal word-addressed memory.
- Supports configurable wait states, APB4 byte strobes and error response (pslverr) for misaligned or out-of-range accesses.
- Successor to the fixed-width zero-wait slave responder. Sits on the APB bus as the DUT the UVM driver/monitor agents talk to.
- Replaces the testbench-driven pready/prdata with real RTL behaviour.

Parameters:
- ADDR_W, 9, paddr width in bits (byte address).
- DATA_W, 32, data width; must be 8, 16, 32 or 64.
- DEPTH, 128, number of DATA_W words; must satisfy DEPTH*(DATA_W/8) <= 2^ADDR_W.
- WAIT_CYCLES, 0, pready-low cycles inserted in each access phase (0..15).

Ports:
- pclk, input, 1, bus clock; all state on rising edge.
- preset, input, 1, asynchronous active-high reset.
- psel, input, 1, slave select.
- penable, input, 1, access phase indicator.
- pwrite, input, 1, 1 = write, 0 = read.
- paddr, input, ADDR_W, byte address.
- pwdata, input, DATA_W, write data.
- pstrb, input, DATA_W/8, write byte enables; ignored on reads.
- pready, output, 1, transfer completes this cycle.
- prdata, output, DATA_W, read data; valid only when pready=1 and the transfer is a read.
- pslverr, output, 1, error flag; valid only when pready=1.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE; wait counter = 0; latched address/control cleared.
  - Outputs pready=0, prdata=0, pslverr=0.
  - Memory contents are not reset and are undefined until written.
- Word index = paddr >> log2(DATA_W/8). Misaligned = low log2(DATA_W/8) bits of paddr nonzero. Out-of-range = index >= DEPTH. Error = misaligned OR out-of-range.
- FSM states: IDLE, ACCESS.
  - IDLE: psel=1 and penable=0 (setup phase) -> latch paddr, pwrite, pwdata, pstrb and error; load counter = WAIT_CYCLES; go to ACCESS.
  - In IDLE, penable=1 without a prior setup is a protocol violation: ignore it, stay in IDLE, pready=0.
  - ACCESS with psel=1 and counter > 0: pready=0; decrement counter.
  - ACCESS with psel=1 and counter = 0: pready=1 (Moore, decoded from registered state). At this clock edge, commit the write if there is no error, then go to IDLE.
  - ACCESS with psel=0: abort. Go to IDLE, commit nothing, never assert pready.
- Latency: setup cycle + WAIT_CYCLES + 1 access cycle. WAIT_CYCLES=0 gives the standard 2-cycle APB transfer.
- Back-to-back transfers: the cycle after pready=1 may be a new setup cycle. It is decoded from IDLE with no dead cycle.
- Write:
  - Byte lane i of mem[index] is updated iff pstrb[i]=1.
  - pstrb=0 is a legal no-op: pready=1, pslverr=0.
  - On error, memory is unchanged and pslverr=1.
- Read:
  - mem[index] is sampled at the setup edge into the prdata holding register; 0 on error.
  - prdata is driven with the holding register only while pready=1 and pwrite=0; it is 0 at all other times.
  - A read in the transfer immediately after a write to the same word returns the new data, because the write commits before the next setup edge.
- pslverr = pready AND latched error; 0 whenever pready=0.
- Inputs changing during ACCESS are ignored apart from psel, since the values latched at setup are used.
- Reset asserted mid-transfer: immediate return to IDLE, outputs go to 0, and no write is committed on that transfer.

Test Plan:
- WAIT_CYCLES=0: write 0xDEADBEEF to paddr 0x010 with pstrb=0xF, then read 0x010 -> pready=1 on the 2nd cycle of each transfer, prdata=0xDEADBEEF, pslverr=0.
- WAIT_CYCLES=3: read paddr 0x004 -> pready low for exactly 3 access cycles, high on the 4th; total transfer 5 cycles.
- Byte strobes: write 0xFFFFFFFF, then write 0x11223344 with pstrb=0x5, then read -> 0xFF22FF44.
- Errors:
  - Write paddr 0x002 (misaligned) -> pslverr=1 with pready, memory unchanged.
  - DEPTH=64, read paddr 0x100 -> pslverr=1, prdata=0.
- Abort: drop psel during a wait cycle of a write to 0x020 -> no pready; a later read of 0x020 returns the old value.
- Reset mid-access: assert preset during the access cycle of a write -> pready/prdata/pslverr go to 0 immediately, the write is not committed, and a subsequent transfer completes normally.

Source files
------------

// File: rtl/apb_slave_mem_wait.sv
// apb_slave_mem_wait: APB4 slave over a word-addressed memory with wait states, byte strobes and pslverr; ports pclk/preset, APB request (psel,penable,pwrite,paddr,pwdata,pstrb), response (pready,prdata,pslverr)
module apb_slave_mem_wait #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                pclk,
  input  logic                preset,
  input  logic                psel,
  input  logic                penable,
  input  logic                pwrite,
  input  logic [ADDR_W-1:0]   paddr,
  input  logic [DATA_W-1:0]   pwdata,
  input  logic [DATA_W/8-1:0] pstrb,
  output logic                pready,
  output logic [DATA_W-1:0]   prdata,
  output logic                pslverr
);
  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = $clog2(STRB_W);
  localparam int IDX_W  = DEPTH > 1 ? $clog2(DEPTH) : 1;
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                wr_q, wr_d, err_q, err_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [STRB_W-1:0]   strb_q, strb_d;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]   word_a;
  logic                setup, misal, oor, err_a, commit;
  assign word_a = paddr >> OFF_W;
  assign misal  = (paddr & ADDR_W'(STRB_W - 1)) != '0;
  assign oor    = {1'b0, word_a} >= (ADDR_W + 1)'(DEPTH);
  assign err_a  = misal | oor;
  assign setup  = state_q == IDLE && psel && !penable;
  assign pready = state_q == ACCESS && cnt_q == 4'd0 && psel;
  assign commit = pready && wr_q && !err_q;
  assign pslverr = pready && err_q;
  assign prdata  = pready && !wr_q ? rdata_q : '0;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    wr_d    = wr_q;
    err_d   = err_q;
    wdata_d = wdata_q;
    strb_d  = strb_q;
    rdata_d = rdata_q;
    if (setup) begin
      state_d = ACCESS;
      cnt_d   = 4'(WAIT_CYCLES);
      idx_d   = word_a[IDX_W-1:0];
      wr_d    = pwrite;
      err_d   = err_a;
      wdata_d = pwdata;
      strb_d  = pstrb;
      rdata_d = err_a ? '0 : mem[word_a[IDX_W-1:0]];
    end else if (state_q == ACCESS) begin
      state_d = !psel || cnt_q == 4'd0 ? IDLE : ACCESS;
      cnt_d   = psel && cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q;
    end
  end
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      wr_q    <= wr_d;
      err_q   <= err_d;
      wdata_q <= wdata_d;
      strb_q  <= strb_d;
      rdata_q <= rdata_d;
    end
  end
  always_ff @(posedge pclk) begin
    if (commit)
      for (int b = 0; b < STRB_W; b++)
        if (strb_q[b]) mem[idx_q][8*b +: 8] <= wdata_q[8*b +: 8];
  end
endmodule

// File: tb/tb_apb_slave_mem_wait.sv
// tb_apb_slave_mem_wait: directed checks of a zero-wait/DEPTH=128 slave (u0) and a 3-wait/DEPTH=64 slave (u1)
module tb_apb_slave_mem_wait;
  logic        pclk = 1'b0, preset = 1'b1;
  logic        psel0 = 1'b0, psel1 = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [8:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [3:0]  pstrb = '0;
  logic        pready0, pslverr0, pready1, pslverr1;
  logic [31:0] prdata0, prdata1;
  int tests = 0, fails = 0;
  always #5 pclk = ~pclk;
  apb_slave_mem_wait #(.ADDR_W(9), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(0)) u0 (
    .pclk(pclk), .preset(preset), .psel(psel0), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready0), .prdata(prdata0), .pslverr(pslverr0));
  apb_slave_mem_wait #(.ADDR_W(9), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(3)) u1 (
    .pclk(pclk), .preset(preset), .psel(psel1), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(pready1), .prdata(prdata1), .pslverr(pslverr1));
  task automatic xfer(input bit s, input bit w, input logic [8:0] a, input logic [31:0] d, input logic [3:0] st,
                      output int waits, output logic [31:0] rd, output logic err, output bit leak);
    psel0 = !s; psel1 = s; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = st;
    @(posedge pclk); #1 penable = 1'b1;
    waits = 0; rd = 'x; err = 1'bx; leak = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge pclk);
      if ((s ? pready1 : pready0) === 1'b1) begin
        rd = s ? prdata1 : prdata0;
        err = s ? pslverr1 : pslverr0;
        break;
      end
      if ((s ? prdata1 : prdata0) !== '0 || (s ? pslverr1 : pslverr0) !== 1'b0) leak = 1'b1;
      waits++;
    end
    @(posedge pclk); #1 psel0 = 1'b0; psel1 = 1'b0; penable = 1'b0;
  endtask
  task automatic test_reset;
    @(negedge pclk);
    tests++; if ({pready0, pslverr0, pready1, pslverr1} !== 4'b0) begin fails++; $display("FAIL reset_flags: got %b expected 0000", {pready0, pslverr0, pready1, pslverr1}); end
    tests++; if (prdata0 !== 32'h0) begin fails++; $display("FAIL reset_prdata0: got %h expected 00000000", prdata0); end
    tests++; if (prdata1 !== 32'h0) begin fails++; $display("FAIL reset_prdata1: got %h expected 00000000", prdata1); end
    @(posedge pclk); #1 preset = 1'b0;
  endtask
  task automatic test_basic;
    int w; logic [31:0] rd; logic e; bit lk;
    xfer(0, 1, 9'h010, 32'hDEADBEEF, 4'hF, w, rd, e, lk);
    tests++; if (w !== 0) begin fails++; $display("FAIL basic_wr_waits: got %0d expected 0", w); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL basic_wr_err: got %b expected 0", e); end
    xfer(0, 0, 9'h010, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (w !== 0) begin fails++; $display("FAIL basic_rd_waits: got %0d expected 0", w); end
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL basic_rd_err: got %b expected 0", e); end
  endtask
  task automatic test_back_to_back;
    int w; logic [31:0] rd; logic e; bit lk;
    xfer(0, 1, 9'h030, 32'hAAAA5555, 4'hF, w, rd, e, lk);
    xfer(0, 0, 9'h030, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (rd !== 32'hAAAA5555) begin fails++; $display("FAIL b2b_rd_data: got %h expected aaaa5555", rd); end
    tests++; if (w !== 0) begin fails++; $display("FAIL b2b_rd_waits: got %0d expected 0", w); end
  endtask
  task automatic test_strobes;
    int w; logic [31:0] rd; logic e; bit lk;
    xfer(0, 1, 9'h040, 32'hFFFFFFFF, 4'hF, w, rd, e, lk);
    xfer(0, 1, 9'h040, 32'h11223344, 4'h5, w, rd, e, lk);
    xfer(0, 0, 9'h040, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (rd !== 32'hFF22FF44) begin fails++; $display("FAIL strb_rd_data: got %h expected ff22ff44", rd); end
    xfer(0, 1, 9'h040, 32'h00000000, 4'h0, w, rd, e, lk);
    tests++; if (w !== 0 || e !== 1'b0) begin fails++; $display("FAIL strb_zero_resp: got waits=%0d err=%b expected waits=0 err=0", w, e); end
    xfer(0, 0, 9'h040, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (rd !== 32'hFF22FF44) begin fails++; $display("FAIL strb_zero_data: got %h expected ff22ff44", rd); end
  endtask
  task automatic test_wait;
    int w; logic [31:0] rd; logic e; bit lk;
    xfer(1, 1, 9'h004, 32'h12345678, 4'hF, w, rd, e, lk);
    tests++; if (w !== 3) begin fails++; $display("FAIL wait_wr_waits: got %0d expected 3", w); end
    xfer(1, 0, 9'h004, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (w !== 3) begin fails++; $display("FAIL wait_rd_waits: got %0d expected 3", w); end
    tests++; if (rd !== 32'h12345678) begin fails++; $display("FAIL wait_rd_data: got %h expected 12345678", rd); end
    tests++; if (lk !== 1'b0) begin fails++; $display("FAIL wait_rd_leak: got %b expected 0", lk); end
  endtask
  task automatic test_errors;
    int w; logic [31:0] rd; logic e; bit lk;
    xfer(0, 1, 9'h012, 32'h00000000, 4'hF, w, rd, e, lk);
    tests++; if (e !== 1'b1 || w !== 0) begin fails++; $display("FAIL err_misal_wr: got err=%b waits=%0d expected err=1 waits=0", e, w); end
    xfer(0, 0, 9'h010, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (rd !== 32'hDEADBEEF) begin fails++; $display("FAIL err_misal_mem: got %h expected deadbeef", rd); end
    xfer(1, 0, 9'h100, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (e !== 1'b1) begin fails++; $display("FAIL err_oor_err: got %b expected 1", e); end
    tests++; if (rd !== 32'h0) begin fails++; $display("FAIL err_oor_data: got %h expected 00000000", rd); end
    tests++; if (w !== 3) begin fails++; $display("FAIL err_oor_waits: got %0d expected 3", w); end
    xfer(0, 0, 9'h100, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (e !== 1'b0) begin fails++; $display("FAIL err_inrange_err: got %b expected 0", e); end
  endtask
  task automatic test_no_setup;
    int w; logic [31:0] rd; logic e; bit lk; bit seen;
    seen = 1'b0;
    psel0 = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 9'h010;
    repeat (3) begin @(negedge pclk); if (pready0 !== 1'b0) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL nosetup_ready: got %b expected 0", seen); end
    @(posedge pclk); #1 psel0 = 1'b0; penable = 1'b0;
    xfer(0, 0, 9'h010, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (rd !== 32'hDEADBEEF || w !== 0) begin fails++; $display("FAIL nosetup_after: got %h waits=%0d expected deadbeef waits=0", rd, w); end
  endtask
  task automatic test_abort;
    int w; logic [31:0] rd; logic e; bit lk; bit seen;
    xfer(1, 1, 9'h020, 32'hCAFEBABE, 4'hF, w, rd, e, lk);
    seen = 1'b0;
    psel1 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h020; pwdata = 32'h55555555; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk); if (pready1 !== 1'b0) seen = 1'b1;
    @(posedge pclk); #1 psel1 = 1'b0; penable = 1'b0;
    repeat (5) begin @(negedge pclk); if (pready1 !== 1'b0) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("FAIL abort_ready: got %b expected 0", seen); end
    @(posedge pclk); #1;
    xfer(1, 0, 9'h020, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (rd !== 32'hCAFEBABE) begin fails++; $display("FAIL abort_data: got %h expected cafebabe", rd); end
  endtask
  task automatic test_reset_mid;
    int w; logic [31:0] rd; logic e; bit lk;
    psel0 = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 9'h010; pwdata = 32'h0BADF00D; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(negedge pclk);
    tests++; if (pready0 !== 1'b1) begin fails++; $display("FAIL rstmid_pre_ready: got %b expected 1", pready0); end
    #1 preset = 1'b1;
    #1;
    tests++; if ({pready0, pslverr0} !== 2'b00 || prdata0 !== 32'h0) begin fails++; $display("FAIL rstmid_outputs: got rdy=%b err=%b rd=%h expected 0 0 00000000", pready0, pslverr0, prdata0); end
    @(posedge pclk); #1 psel0 = 1'b0; penable = 1'b0; preset = 1'b0;
    xfer(0, 0, 9'h010, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (rd !== 32'hDEADBEEF || w !== 0 || e !== 1'b0) begin fails++; $display("FAIL rstmid_after: got %h waits=%0d err=%b expected deadbeef 0 0", rd, w, e); end
    xfer(1, 0, 9'h004, 32'h0, 4'h0, w, rd, e, lk);
    tests++; if (rd !== 32'h12345678 || w !== 3) begin fails++; $display("FAIL rstmid_u1_after: got %h waits=%0d expected 12345678 3", rd, w); end
  endtask
  initial begin
    repeat (2) @(posedge pclk);
    test_reset;
    test_basic;
    test_back_to_back;
    test_strobes;
    test_wait;
    test_errors;
    test_no_setup;
    test_abort;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
